// File: rtl/ej32_pkg.sv
// Shared constants and types for the eJ32 memory controller.
package ej32_pkg;

  localparam int unsigned DEF_ASZ     = 17;
  localparam int unsigned DEF_TIB     = 32'h1000;
  localparam int unsigned DEF_TIB_SZ  = 256;
  localparam int unsigned DEF_OBUF    = 32'h1400;
  localparam int unsigned DEF_OBUF_SZ = 1024;
  localparam int unsigned DEF_TXD     = 8;

  // Which agent owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    CORE_WR = 2'd0,
    RX_WR   = 2'd1,
    READ    = 2'd2
  } cyc_t;

endpackage

// File: rtl/ej32_mem_ctl_if.sv
// Console byte channel: TX bytes out of the controller, RX bytes in.
// Handshake: a byte moves on a cycle where both valid and ready are high;
// valid never waits for ready, and the sender holds data while valid is high.
interface ej32_mem_ctl_if;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;

  modport master (
    output tx_data_o, tx_valid_o, rx_ready_o,
    input  tx_ready_i, rx_data_i, rx_valid_i
  );

  modport slave (
    input  tx_data_o, tx_valid_o, rx_ready_o,
    output tx_ready_i, rx_data_i, rx_valid_i
  );
endinterface

// File: rtl/ej32_fifo.sv
// Small synchronous FIFO with registered occupancy count.
module ej32_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [W-1:0]         din_i,
  input  logic                 pop_i,
  output logic [W-1:0]         dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [$clog2(D):0]   count_o
);
  localparam int unsigned AW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(D));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and count next-state; pointers wrap naturally (D is a power of 2).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer/count registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/ej32_mem_ctl.sv
// Byte RAM arbiter for the eJ32 core: core writes, console RX injection,
// and fetch/load reads share one port; OBUF writes are mirrored to TX.
module ej32_mem_ctl
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ     = DEF_ASZ,
  parameter int unsigned TIB     = DEF_TIB,
  parameter int unsigned TIB_SZ  = DEF_TIB_SZ,
  parameter int unsigned OBUF    = DEF_OBUF,
  parameter int unsigned OBUF_SZ = DEF_OBUF_SZ,
  parameter int unsigned TXD     = DEF_TXD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASZ-1:0]       pc_i,
  input  logic                 ls_asel_i,
  input  logic [ASZ-1:0]       ls_addr_i,
  input  logic [7:0]           ls_data_i,
  input  logic                 ls_dwe_i,
  output logic [ASZ-1:0]       mem_addr_o,
  output logic [7:0]           mem_data_o,
  output logic                 mem_we_o,
  input  logic [7:0]           mem_data_i,
  output logic [7:0]           data_o,
  output logic                 data_vld_o,
  output logic                 stall_o,
  ej32_mem_ctl_if.master       con,
  output cyc_t                 dbg_cyc_o,
  output logic [ASZ-1:0]       dbg_rx_ptr_o,
  output logic [$clog2(TXD):0] dbg_tx_cnt_o
);
  localparam int unsigned TBITS = $clog2(TIB_SZ);
  localparam logic [ASZ:0] OB_LO = (ASZ+1)'(OBUF);
  localparam logic [ASZ:0] OB_HI = (ASZ+1)'(OBUF + OBUF_SZ);

  cyc_t           cyc;
  logic [ASZ-1:0] rx_ptr_q, rx_ptr_d;
  logic           data_vld_q;
  logic           ow, push, pop, tx_full, tx_empty;

  assign ow = ({1'b0, ls_addr_i} >= OB_LO) && ({1'b0, ls_addr_i} < OB_HI);

  // Cycle arbitration: core write, then RX steal, then read. Reset masks strobes.
  always_comb begin
    cyc            = READ;
    mem_addr_o     = ls_asel_i ? ls_addr_i : pc_i;
    mem_data_o     = ls_data_i;
    mem_we_o       = 1'b0;
    stall_o        = 1'b0;
    con.rx_ready_o = 1'b0;
    push           = 1'b0;
    rx_ptr_d       = rx_ptr_q;
    if (ls_dwe_i) begin
      cyc        = CORE_WR;
      mem_addr_o = ls_addr_i;
      if (ow && tx_full) begin
        stall_o = 1'b1;
      end else begin
        mem_we_o = 1'b1;
        push     = ow;
      end
    end else if (con.rx_valid_i) begin
      cyc            = RX_WR;
      mem_addr_o     = rx_ptr_q;
      mem_data_o     = con.rx_data_i;
      mem_we_o       = 1'b1;
      stall_o        = 1'b1;
      con.rx_ready_o = 1'b1;
      rx_ptr_d       = {rx_ptr_q[ASZ-1:TBITS], rx_ptr_q[TBITS-1:0] + TBITS'(1)};
    end
    if (rst) begin
      mem_we_o       = 1'b0;
      stall_o        = 1'b0;
      con.rx_ready_o = 1'b0;
      push           = 1'b0;
    end
  end

  // RX ring pointer and read-data-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ptr_q   <= ASZ'(TIB);
      data_vld_q <= 1'b0;
    end else begin
      rx_ptr_q   <= rx_ptr_d;
      data_vld_q <= !stall_o;
    end
  end

  assign pop            = con.tx_valid_o && con.tx_ready_i;
  assign con.tx_valid_o = !tx_empty;
  assign data_o         = mem_data_i;
  assign data_vld_o     = data_vld_q;
  assign dbg_cyc_o      = cyc;
  assign dbg_rx_ptr_o   = rx_ptr_q;

  ej32_fifo #(.W(8), .D(TXD)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (ls_data_i),
    .pop_i   (pop),
    .dout_o  (con.tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (dbg_tx_cnt_o)
  );
endmodule

// File: doc/ej32_mem_ctl.md
Name: ej32_mem_ctl

Overview:
- Single-port, byte-wide memory controller that sits directly downstream of the eJ32 load/store unit and instruction fetch.
- Muxes the fetch address and the load/store address onto one synchronous byte RAM, and returns read data to the core one cycle later.
- Snoops core writes into the output-buffer window and pushes those bytes into a TX FIFO for the console.
- Injects console RX bytes into the input-buffer ring by stealing memory cycles.

Parameters:
- ASZ, 17, address width in bits (128K byte space).
- TIB, 'h1000, base address of the input buffer ring.
- TIB_SZ, 256, input ring size in bytes; must be a power of 2.
- OBUF, 'h1400, base address of the output buffer window.
- OBUF_SZ, 1024, output window size in bytes.
- TXD, 8, TX FIFO depth in entries; must be a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- pc_i  in  ASZ  instruction fetch address
- ls_asel_i  in  1  1 = use ls_addr_i, 0 = use pc_i
- ls_addr_i  in  ASZ  load/store address
- ls_data_i  in  8  byte to write
- ls_dwe_i  in  1  core write enable
- mem_addr_o  out  ASZ  RAM address
- mem_data_o  out  8  RAM write data
- mem_we_o  out  1  RAM write enable
- mem_data_i  in  8  RAM read data; valid 1 cycle after address
- data_o  out  8  read data returned to the core
- data_vld_o  out  1  data_o belongs to the core's previous-cycle access
- stall_o  out  1  core must hold all ls_* and pc_i inputs this cycle
- tx_data_o  out  8  console TX byte
- tx_valid_o  out  1  TX FIFO not empty
- tx_ready_i  in  1  console accepts tx_data_o
- rx_data_i  in  8  console RX byte
- rx_valid_i  in  1  RX byte offered
- rx_ready_o  out  1  RX byte accepted this cycle

Behaviour:
- Reset state (async, rst=1):
  - tx FIFO empty; tx_valid_o=0.
  - rx_ptr=TIB.
  - mem_we_o=0, stall_o=0, rx_ready_o=0, data_vld_o=0.
  - mem_addr_o=pc_i (combinational).
- Cycle classification, evaluated combinationally each cycle in priority order:
  1. CORE_WR: ls_dwe_i=1.
     - ow = ls_addr_i in [OBUF, OBUF+OBUF_SZ).
     - If ow=1 and the TX FIFO is full: stall_o=1, mem_we_o=0, no push.
     - Otherwise: mem_addr_o=ls_addr_i, mem_data_o=ls_data_i, mem_we_o=1. If ow=1, push ls_data_i.
  2. RX_WR: ls_dwe_i=0 and rx_valid_i=1.
     - mem_addr_o=rx_ptr, mem_data_o=rx_data_i, mem_we_o=1.
     - rx_ready_o=1, stall_o=1.
     - rx_ptr advances by 1 at the next edge.
  3. READ: all other cycles.
     - mem_addr_o = ls_asel_i ? ls_addr_i : pc_i; mem_we_o=0.
- rx_ready_o=0 in any cycle that is not RX_WR.
- rx_ptr wraps from TIB+TIB_SZ-1 back to TIB; only the low log2(TIB_SZ) bits increment. There is no overflow detection; software owns consumption.
- data_o = mem_data_i (combinational passthrough).
- data_vld_o is a register loaded with !stall_o, so it is 0 in the cycle after a stolen or stalled cycle.
- TX FIFO:
  - Pop when tx_valid_o & tx_ready_i.
  - Full is computed from the registered count only: a pop in the same cycle does not relieve a full-stall. The push retries next cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - tx_data_o shows the head entry; valid in the same cycle as tx_valid_o.
- Address compare is unsigned, full ASZ width. OBUF+OBUF_SZ must not exceed 2^ASZ.
- A stalled core write is held by the core and completes in the first cycle the FIFO is not full. Exactly one RAM write and one FIFO push occur per held write.
- Reset mid-operation: an in-flight stalled write is dropped, the FIFO is emptied, and rx_ptr returns to TIB.

Decomposition:
- ej32_pkg holds: TIB/OBUF/TIB_SZ/OBUF_SZ constants, and a cyc_t enum {CORE_WR, RX_WR, READ} for debug visibility.
- Sub-module ej32_fifo (parameterised width 8, depth TXD; push/pop/full/empty/count, asynchronous active-high reset) implements the TX FIFO.

Test Plan:
- Reset, pc_i=0x0010, ls_asel_i=0 -> mem_addr_o=0x0010, mem_we_o=0, tx_valid_o=0. RAM preloaded 0xA5 at 0x0010 -> data_o=0xA5, data_vld_o=1 next cycle.
- Core write ls_addr_i=0x1400, ls_data_i=0x41, tx_ready_i=0 -> mem_we_o=1 at 0x1400. tx_valid_o=1 next cycle with tx_data_o=0x41.
- 9 consecutive OBUF writes with tx_ready_i=0:
  - Writes 1–8 proceed without stall.
  - 9th write raises stall_o and holds mem_we_o=0.
  - Raise tx_ready_i one cycle -> 9th write still stalls that cycle, completes the following cycle.
- rx_valid_i=1 with bytes 0x31,0x32 while ls_dwe_i=0 -> writes at 0x1000 and 0x1001, stall_o=1 on both cycles, data_vld_o=0 on the cycles after.
- rx_valid_i=1 with ls_dwe_i=1 to 0x2000 -> core write wins, rx_ready_o=0, rx_ptr unchanged.
- Inject 257 RX bytes -> 257th lands at 0x1000 (wrap). Assert rst mid-sequence -> rx_ptr=0x1000, tx_valid_o=0 immediately.
